// File: rtl/counter_axi_lite_slave.sv
// -----------------------------------------------------------------------------
// counter_axi_lite_slave
//
// AXI4-Lite responder that lets the PS control and observe the free-running
// counter core. The PS writes enable / clear / switch-override fields and
// reads back the live counter value, the LED state and a scratch register.
//
// Register map (byte address, bits [1:0] ignored):
//   0x0 CTRL    RW  bit0 enable, bit1 clear (write-1 pulse, reads 0),
//                   bits[7:4] switch override, other bits read 0
//   0x4 COUNT   RO  counter_in zero-extended (writes accepted, no effect)
//   0x8 LED     RO  bits[3:0] led_in
//   0xC SCRATCH RW  32-bit general purpose
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_aw* / s_w* / s_b*      AXI4-Lite write address / data / response
//   s_ar* / s_r*             AXI4-Lite read address / data
//   counter_in, led_in       status from the counter core
//   cnt_enable, cnt_clear,   control to the counter core (cnt_clear is a
//   sw_out                   single-cycle pulse the cycle after the write)
//
// Configuration macro:
//   COUNTER_AXI_WSTRB_EN  when defined, writes honour s_wstrb per byte;
//                         otherwise s_wstrb is ignored and whole words are
//                         written.
//
// Only one transaction per channel is ever outstanding. Ready outputs are
// registered so that every handshake-related output is low during reset.
// -----------------------------------------------------------------------------
module counter_axi_lite_slave #(
   parameter int ADDR_WIDTH  = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   // write address channel
   input  logic [ADDR_WIDTH-1:0]     s_awaddr,
   input  logic                      s_awvalid,
   output logic                      s_awready,
   // write data channel
   input  logic [DATA_WIDTH-1:0]     s_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
   input  logic                      s_wvalid,
   output logic                      s_wready,
   // write response channel
   output logic [1:0]                s_bresp,
   output logic                      s_bvalid,
   input  logic                      s_bready,
   // read address channel
   input  logic [ADDR_WIDTH-1:0]     s_araddr,
   input  logic                      s_arvalid,
   output logic                      s_arready,
   // read data channel
   output logic [DATA_WIDTH-1:0]     s_rdata,
   output logic [1:0]                s_rresp,
   output logic                      s_rvalid,
   input  logic                      s_rready,
   // counter core side
   input  logic [COUNT_WIDTH-1:0]    counter_in,
   input  logic [3:0]                led_in,
   output logic                      cnt_enable,
   output logic                      cnt_clear,
   output logic [3:0]                sw_out
);

   localparam int         NBYTES       = DATA_WIDTH / 8;
   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_COUNT   = 2'd1;
   localparam logic [1:0] ADDR_LED     = 2'd2;
   localparam logic [1:0] ADDR_SCRATCH = 2'd3;
   localparam logic [1:0] RESP_OKAY    = 2'b00;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   w_state_t                w_state_q, w_state_d;
   logic                    awready_q, awready_d;
   logic                    wready_q, wready_d;
   logic                    bvalid_q, bvalid_d;
   logic                    aw_held_q, aw_held_d;
   logic                    w_held_q, w_held_d;
   logic [1:0]              awsel_q, awsel_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [NBYTES-1:0]       wstrb_q, wstrb_d;

   logic                    enable_q, enable_d;
   logic                    clear_q, clear_d;
   logic [3:0]              sw_q, sw_d;
   logic [DATA_WIDTH-1:0]   scratch_q, scratch_d;

   r_state_t                r_state_q, r_state_d;
   logic                    arready_q, arready_d;
   logic                    rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

   // ---------------------------------------------------------------------
   // Register read views (shared by the read mux and the strobe merge)
   // ---------------------------------------------------------------------
   logic [DATA_WIDTH-1:0]   ctrl_view;
   logic [DATA_WIDTH-1:0]   count_view;
   logic [DATA_WIDTH-1:0]   led_view;

   always_comb begin
      // clear is a pulse and always reads back as 0
      ctrl_view      = '0;
      ctrl_view[0]   = enable_q;
      ctrl_view[7:4] = sw_q;

      count_view                  = '0;
      count_view[COUNT_WIDTH-1:0] = counter_in;

      led_view       = '0;
      led_view[3:0]  = led_in;
   end

   // ---------------------------------------------------------------------
   // Write path
   // ---------------------------------------------------------------------
   logic                    aw_hs;
   logic                    w_hs;
   logic                    have_aw;
   logic                    have_w;
   logic                    commit;
   logic [1:0]              cur_awsel;
   logic [DATA_WIDTH-1:0]   cur_wdata;
   logic [NBYTES-1:0]       cur_wstrb;
   logic [DATA_WIDTH-1:0]   merged_word;

   assign aw_hs     = s_awvalid & awready_q;
   assign w_hs      = s_wvalid & wready_q;
   assign have_aw   = aw_held_q | aw_hs;
   assign have_w    = w_held_q | w_hs;
   // The write commits on the edge where both halves are available, whether
   // they arrived on earlier cycles (held) or are handshaking right now.
   assign commit    = (w_state_q == W_IDLE) & have_aw & have_w;
   assign cur_awsel = aw_held_q ? awsel_q : s_awaddr[3:2];
   assign cur_wdata = w_held_q  ? wdata_q : s_wdata;
   assign cur_wstrb = w_held_q  ? wstrb_q : s_wstrb;

`ifdef COUNTER_AXI_WSTRB_EN
   logic [DATA_WIDTH-1:0]   old_word;

   // Only CTRL and SCRATCH are writable; merging against the CTRL view keeps
   // the clear bit at 0 when byte 0 is not strobed.
   assign old_word = (cur_awsel == ADDR_CTRL) ? ctrl_view : scratch_q;

   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_strb_merge
      assign merged_word[gi*8 +: 8] = cur_wstrb[gi] ? cur_wdata[gi*8 +: 8]
                                                    : old_word[gi*8 +: 8];
   end
`else
   assign merged_word = cur_wdata;
`endif

   // Address LSBs are byte offsets within a word; strobes only matter when
   // the per-byte write option is built in.
   logic unused_ok;
   assign unused_ok = ^{s_awaddr[1:0], s_araddr[1:0], cur_wstrb};

   // Register file update
   always_comb begin
      enable_d  = enable_q;
      sw_d      = sw_q;
      scratch_d = scratch_q;
      clear_d   = 1'b0;
      if (commit) begin
         case (cur_awsel)
            ADDR_CTRL: begin
               enable_d = merged_word[0];
               sw_d     = merged_word[7:4];
               clear_d  = merged_word[1];
            end
            ADDR_SCRATCH: begin
               scratch_d = merged_word;
            end
            default: ; // COUNT and LED are read-only
         endcase
      end
   end

   // Write FSM
   always_comb begin
      w_state_d = w_state_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awsel_d   = awsel_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               awsel_d   = s_awaddr[3:2];
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = s_wdata;
               wstrb_d  = s_wstrb;
            end
            // each channel stays ready until its half has been captured
            awready_d = ~have_aw;
            wready_d  = ~have_w;
            if (commit) begin
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b0;
               bvalid_d  = 1'b1;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (s_bready) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: begin
            w_state_d = W_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Read path
   // ---------------------------------------------------------------------
   logic                    ar_hs;
   logic [DATA_WIDTH-1:0]   rd_word;

   assign ar_hs = s_arvalid & arready_q;

   // Reads use the registered (pre-write) values, so a read and write to the
   // same register on the same edge returns the old contents.
   always_comb begin
      case (s_araddr[3:2])
         ADDR_CTRL:  rd_word = ctrl_view;
         ADDR_COUNT: rd_word = count_view;
         ADDR_LED:   rd_word = led_view;
         default:    rd_word = scratch_q;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               rdata_d   = rd_word;
               rvalid_d  = 1'b1;
               arready_d = 1'b0;
               r_state_d = R_DATA;
            end else begin
               arready_d = 1'b1;
            end
         end
         R_DATA: begin
            if (s_rready) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               r_state_d = R_IDLE;
            end
         end
         default: begin
            r_state_d = R_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awsel_q   <= 2'd0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         enable_q  <= 1'b0;
         clear_q   <= 1'b0;
         sw_q      <= 4'h0;
         scratch_q <= '0;
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awsel_q   <= awsel_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         enable_q  <= enable_d;
         clear_q   <= clear_d;
         sw_q      <= sw_d;
         scratch_q <= scratch_d;
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign s_awready  = awready_q;
   assign s_wready   = wready_q;
   assign s_bvalid   = bvalid_q;
   assign s_bresp    = RESP_OKAY;
   assign s_arready  = arready_q;
   assign s_rvalid   = rvalid_q;
   assign s_rdata    = rdata_q;
   assign s_rresp    = RESP_OKAY;
   assign cnt_enable = enable_q;
   assign cnt_clear  = clear_q;
   assign sw_out     = sw_q;

endmodule

// File: doc/counter_axi_lite_slave.md
Name: counter_axi_lite_slave

Overview:
AXI4-Lite responder that exposes the free-running counter block to the Zynq PS.
- PS writes control fields: enable, clear pulse and a 4-bit switch override. These drive the counter's control inputs.
- PS reads back the counter value, the LED state and a scratch register.
- Sits between the PS AXI GP master interconnect and the counter core inside the custom IP wrapper.

Parameters:
ADDR_WIDTH, 4, byte address width; 4 word-aligned registers.
DATA_WIDTH, 32, AXI data width; only 32 is supported.
COUNT_WIDTH, 32, width of counter_in; zero-extended to 32 on read.

Ports:
clk  in  1  system clock (AXI ACLK domain)
rst  in  1  asynchronous, active-high reset
s_awaddr  in  ADDR_WIDTH  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  write byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  ADDR_WIDTH  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
counter_in  in  COUNT_WIDTH  live counter value from counter core
led_in  in  4  LED state from counter core
cnt_enable  out  1  counter enable
cnt_clear  out  1  one-cycle clear pulse to counter
sw_out  out  4  switch override to counter core

Behaviour:
Reset (async, rst=1):
- All ready/valid outputs = 0.
- bresp = rresp = 2'b00; rdata = 0.
- cnt_enable = 0, cnt_clear = 0, sw_out = 4'h0, scratch = 0.
- Both FSMs go to IDLE.
- Reset asserted mid-transaction abandons it; no response is issued after reset release.

Register map (address bits [3:2]; bits [1:0] ignored):
- 0x0 CTRL, RW: bit0 = enable, bit1 = clear (write-1 pulse, always reads 0), bits[7:4] = sw_out, others read 0.
- 0x4 COUNT, RO: counter_in zero-extended. Writes return OKAY and have no effect.
- 0x8 LED, RO: bits[3:0] = led_in, others 0.
- 0xC SCRATCH, RW: 32-bit.

Write FSM (W_IDLE, W_RESP):
- W_IDLE: awready = 1 until AW is captured; wready = 1 until W is captured. AW and W are captured independently, in either order or in the same cycle.
- When both are held: the register update commits on that clock edge, bvalid = 1, bresp = OKAY (2'b00), FSM goes to W_RESP.
- W_RESP: awready = wready = 0; bvalid holds until bready. Then go to W_IDLE and clear the captured flags.
- Write to CTRL with bit1 = 1: cnt_clear = 1 for exactly one cycle, the cycle after commit.

Read FSM (R_IDLE, R_DATA):
- R_IDLE: arready = 1. On arvalid & arready, latch rdata from the addressed register in that same cycle; go to R_DATA with rvalid = 1, rresp = OKAY.
- Read latency: 1 cycle from AR handshake to rvalid.
- R_DATA: arready = 0; rdata/rvalid hold stable until rready. Then go to R_IDLE.
- A COUNT read returns the value sampled at the AR handshake edge. Later counter changes do not alter the held rdata.

Simultaneous read/write to the same register in the same cycle: the read returns the pre-write value.

No outstanding transactions beyond one per channel.

Optional Feature:
COUNTER_AXI_WSTRB_EN:
- Defined: writes honour s_wstrb per byte. A byte with strobe 0 keeps its old value. For CTRL, cnt_clear pulses only if wstrb[0] = 1 and bit1 = 1.
- Undefined: s_wstrb is ignored and every write updates the full word.

Test Plan:
1. Reset, then read 0x0, 0x8, 0xC -> all rdata = 0x00000000, rresp = 00, cnt_enable = 0, sw_out = 0; rvalid exactly 1 cycle after AR handshake.
2. Write 0x0 = 0x00000041, AW before W by 3 cycles -> one bvalid only after W accepted, bresp = 00; cnt_enable = 1, sw_out = 4'h4; read 0x0 -> 0x00000041.
3. Write 0x0 = 0x00000003 -> cnt_clear high exactly 1 cycle; read 0x0 -> 0x00000001.
4. Hold bready = 0 for 5 cycles after a SCRATCH write of 0xDEADBEEF -> bvalid stays 1, awready/wready stay 0; a second write issued meanwhile stalls. Read 0xC -> 0xDEADBEEF.
5. counter_in incrementing; AR to 0x4 with rready low for 4 cycles -> rdata constant at the value sampled on the handshake edge.
6. With COUNTER_AXI_WSTRB_EN: SCRATCH = 0xDEADBEEF, then write 0x11223344 with wstrb = 4'b0101 -> read 0xC = 0xDE22BE44. Without the macro -> 0x11223344.
